// File: rtl/vsync_timing_decoder_if.sv
// Sync inputs and timing-measurement outputs of vsync_timing_decoder.
// The master drives hsync/vsync (a video source or a bench); the slave is the decoder.
interface vsync_timing_decoder_if #(
    parameter int yresolution = 10
);
    logic                   hsync_in;
    logic                   vsync_in;
    logic [yresolution-1:0] yposition;
    logic [yresolution-1:0] line_count;
    logic [yresolution-1:0] sync_lines;
    logic                   frame_start;
    logic                   locked;
    logic                   sync_error;
    logic [15:0]            line_period;

    modport master (
        output hsync_in,
        output vsync_in,
        input  yposition,
        input  line_count,
        input  sync_lines,
        input  frame_start,
        input  locked,
        input  sync_error,
        input  line_period
    );

    modport slave (
        input  hsync_in,
        input  vsync_in,
        output yposition,
        output line_count,
        output sync_lines,
        output frame_start,
        output locked,
        output sync_error,
        output line_period
    );
endinterface

// File: rtl/vsync_timing_decoder.sv
// Recovers the vertical line position from active-low hsync/vsync, measures frame and sync length, tracks lock.
// Optional macro VSYNC_LINE_PERIOD_MEASURE_EN adds a CLK-cycles-per-line measurement that also feeds the lock check.
module vsync_timing_decoder #(
    parameter int yresolution = 10,
    parameter int LockFrames  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    vsync_timing_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int                     MW           = $clog2(LockFrames) + 1;
    localparam logic [yresolution-1:0] LINE_MAX     = '1;
    localparam logic [MW-1:0]          MATCH_TARGET = MW'(LockFrames - 1);

    logic                   hs_meta_q, hs_meta_d;
    logic                   hs_sync_q, hs_sync_d;
    logic                   hs_prev_q, hs_prev_d;
    logic                   vs_meta_q, vs_meta_d;
    logic                   vs_sync_q, vs_sync_d;
    logic                   vs_prev_q, vs_prev_d;
    logic [yresolution-1:0] lcount_q, lcount_d;
    logic [yresolution-1:0] scount_q, scount_d;
    logic [yresolution-1:0] line_count_q, line_count_d;
    logic [yresolution-1:0] sync_lines_q, sync_lines_d;
    logic [MW-1:0]          match_q, match_d;
    state_t                 state_q, state_d;
    logic                   frame_start_q, frame_start_d;
    logic                   locked_q, locked_d;
    logic                   sync_error_q, sync_error_d;

    logic                   line_tick;
    logic                   vs_start;
    logic                   vs_end;
    logic                   timeout;
    logic                   captures_match;
    logic                   period_mismatch;
    logic [yresolution-1:0] cap_lines;
    logic [yresolution-1:0] cap_sync;
    logic [MW-1:0]          match_next;

    assign line_tick = hs_prev_q & ~hs_sync_q;
    assign vs_start  = vs_prev_q & ~vs_sync_q;
    assign vs_end    = ~vs_prev_q & vs_sync_q;

    // A tick landing on the vsync rising edge still belongs to the frame being closed.
    assign cap_lines      = lcount_q + yresolution'(line_tick);
    assign cap_sync       = scount_q + yresolution'(line_tick);
    assign captures_match = (cap_lines == line_count_q) && (cap_sync == sync_lines_q);
    assign match_next     = captures_match ? (match_q + MW'(1)) : '0;
    assign timeout        = line_tick && !vs_end && (lcount_q == LINE_MAX);

`ifdef VSYNC_LINE_PERIOD_MEASURE_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] line_period_q, line_period_d;
    logic [15:0] period_new;
    logic [16:0] new_wide;
    logic [16:0] old_wide;
    logic        period_bad_q, period_bad_d;
    logic        period_jump;

    // Any line whose period moves by more than one cycle marks the current frame as suspect.
    always_comb begin
        period_new      = (cyc_q == 16'hFFFF) ? 16'hFFFF : (cyc_q + 16'd1);
        new_wide        = {1'b0, period_new};
        old_wide        = {1'b0, line_period_q};
        period_jump     = line_tick && ((new_wide > (old_wide + 17'd1)) || (old_wide > (new_wide + 17'd1)));
        cyc_d           = line_tick ? 16'd0 : period_new;
        line_period_d   = line_tick ? period_new : line_period_q;
        period_bad_d    = vs_end ? 1'b0 : (period_bad_q | period_jump);
        period_mismatch = period_bad_q | period_jump;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cyc_q         <= 16'd0;
            line_period_q <= 16'd0;
            period_bad_q  <= 1'b0;
        end else begin
            cyc_q         <= cyc_d;
            line_period_q <= line_period_d;
            period_bad_q  <= period_bad_d;
        end
    end

    assign bus.line_period = line_period_q;
`else
    assign period_mismatch = 1'b0;
    assign bus.line_period = 16'd0;
`endif

    always_comb begin
        hs_meta_d     = bus.hsync_in;
        hs_sync_d     = hs_meta_q;
        hs_prev_d     = hs_sync_q;
        vs_meta_d     = bus.vsync_in;
        vs_sync_d     = vs_meta_q;
        vs_prev_d     = vs_sync_q;
        lcount_d      = lcount_q;
        scount_d      = scount_q;
        line_count_d  = line_count_q;
        sync_lines_d  = sync_lines_q;
        match_d       = match_q;
        state_d       = state_q;
        frame_start_d = 1'b0;
        locked_d      = locked_q;
        sync_error_d  = 1'b0;

        if (vs_end) begin
            lcount_d = '0;
        end else if (line_tick && !timeout) begin
            lcount_d = lcount_q + yresolution'(1);
        end

        if (vs_start) begin
            scount_d = yresolution'(line_tick);
        end else if (line_tick && !vs_sync_q && (scount_q != LINE_MAX)) begin
            scount_d = scount_q + yresolution'(1);
        end

        case (state_q)
            SEARCH: begin
                if (vs_end) begin
                    state_d = MEASURE;
                    match_d = '0;
                end
            end
            MEASURE: begin
                if (vs_end) begin
                    line_count_d  = cap_lines;
                    sync_lines_d  = cap_sync;
                    frame_start_d = 1'b1;
                    match_d       = match_next;
                    if (match_next == MATCH_TARGET) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (vs_end) begin
                    line_count_d  = cap_lines;
                    sync_lines_d  = cap_sync;
                    frame_start_d = 1'b1;
                    if (!captures_match || period_mismatch) begin
                        state_d      = MEASURE;
                        locked_d     = 1'b0;
                        sync_error_d = 1'b1;
                        match_d      = '0;
                    end
                end
            end
            default: begin
                state_d  = SEARCH;
                locked_d = 1'b0;
                match_d  = '0;
            end
        endcase

        // A frame too long to count cannot be trusted; drop back and reacquire.
        if (timeout) begin
            state_d      = SEARCH;
            locked_d     = 1'b0;
            match_d      = '0;
            sync_error_d = (state_q != SEARCH);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hs_meta_q     <= 1'b1;
            hs_sync_q     <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_meta_q     <= 1'b1;
            vs_sync_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            lcount_q      <= '0;
            scount_q      <= '0;
            line_count_q  <= '0;
            sync_lines_q  <= '0;
            match_q       <= '0;
            state_q       <= SEARCH;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            hs_meta_q     <= hs_meta_d;
            hs_sync_q     <= hs_sync_d;
            hs_prev_q     <= hs_prev_d;
            vs_meta_q     <= vs_meta_d;
            vs_sync_q     <= vs_sync_d;
            vs_prev_q     <= vs_prev_d;
            lcount_q      <= lcount_d;
            scount_q      <= scount_d;
            line_count_q  <= line_count_d;
            sync_lines_q  <= sync_lines_d;
            match_q       <= match_d;
            state_q       <= state_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign bus.yposition   = lcount_q;
    assign bus.line_count  = line_count_q;
    assign bus.sync_lines  = sync_lines_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.sync_error  = sync_error_q;

endmodule

// File: tb/tb_vsync_timing_decoder.sv
// Scoreboard bench for vsync_timing_decoder: frame stimulus queues expected frame_start/sync_error events,
// a negedge monitor pops and compares them. Honors VSYNC_LINE_PERIOD_MEASURE_EN when defined.
module tb_vsync_timing_decoder;

    localparam int YRES = 10;

    typedef struct packed {
        logic            fs;
        logic            err;
        logic            lk;
        logic [YRES-1:0] lc;
        logic [YRES-1:0] sl;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    vsync_timing_decoder_if #(.yresolution(YRES)) bus ();

    vsync_timing_decoder #(
        .yresolution(YRES),
        .LockFrames (2)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic expect_event(input logic fs, input logic err, input logic lk, input int lc, input int sl);
        exp_t e;
        e.fs  = fs;
        e.err = err;
        e.lk  = lk;
        e.lc  = YRES'(lc);
        e.sl  = YRES'(sl);
        exp_q.push_back(e);
    endtask

    // Line starts with a one-cycle hsync low; vsync moves mid-line unless align_rise puts its rise on the hsync edge.
    task automatic apply_stimulus(input int total, input int sync, input int period,
                                  input int long_line, input int long_period, input bit align_rise);
        int   per;
        logic low;
        for (int l = 0; l < total; l++) begin
            per = (l == long_line) ? long_period : period;
            for (int c = 0; c < per; c++) begin
                @(negedge CLK);
                bus.hsync_in = (c == 0) ? 1'b0 : 1'b1;
                low = (sync > 0) && ((l == 0 && c >= 4) || (l > 0 && l < sync) ||
                                     (!align_rise && l == sync && c < 4));
                bus.vsync_in = ~low;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_yposition"}, 32'(bus.yposition), 0);
        check_output({tag, "_line_count"}, 32'(bus.line_count), 0);
        check_output({tag, "_sync_lines"}, 32'(bus.sync_lines), 0);
        check_output({tag, "_frame_start"}, 32'(bus.frame_start), 0);
        check_output({tag, "_locked"}, 32'(bus.locked), 0);
        check_output({tag, "_sync_error"}, 32'(bus.sync_error), 0);
        check_output({tag, "_line_period"}, 32'(bus.line_period), 0);
    endtask

    // Monitor: every frame_start or sync_error pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge CLK);
            if (!RESET && (bus.frame_start || bus.sync_error)) begin
                act.fs  = bus.frame_start;
                act.err = bus.sync_error;
                act.lk  = bus.locked;
                act.lc  = bus.line_count;
                act.sl  = bus.sync_lines;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_event actual fs=%0b err=%0b locked=%0b lines=%0d sync=%0d required none",
                             act.fs, act.err, act.lk, act.lc, act.sl);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("[TB] FAIL event actual fs=%0b err=%0b locked=%0b lines=%0d sync=%0d required fs=%0b err=%0b locked=%0b lines=%0d sync=%0d",
                                 act.fs, act.err, act.lk, act.lc, act.sl, e.fs, e.err, e.lk, e.lc, e.sl);
                    end
                end
                if (bus.frame_start) begin
                    check_output("ypos_at_frame_start", 32'(bus.yposition), 0);
                end
            end
        end
    end

    initial begin
        RESET        = 1'b1;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        repeat (4) @(negedge CLK);
        check_all_zero("reset");
        RESET = 1'b0;

        $display("[TB] acquire with 525-line frames");
        apply_stimulus(525, 2, 8, -1, 8, 1'b0);
        check_output("search_to_measure_locked", 32'(bus.locked), 0);
        expect_event(1, 0, 0, 525, 2);
        apply_stimulus(525, 2, 8, -1, 8, 1'b0);
        expect_event(1, 0, 1, 525, 2);
        apply_stimulus(525, 2, 8, -1, 8, 1'b0);

        $display("[TB] 526-line frames: lock loss then relock");
        expect_event(1, 0, 1, 525, 2);
        apply_stimulus(526, 2, 8, -1, 8, 1'b0);
        expect_event(1, 1, 0, 526, 2);
        apply_stimulus(526, 2, 8, -1, 8, 1'b0);
        expect_event(1, 0, 1, 526, 2);
        apply_stimulus(526, 2, 8, -1, 8, 1'b1);
        expect_event(1, 0, 1, 526, 2);
        apply_stimulus(526, 2, 8, -1, 8, 1'b0);

        $display("[TB] reset at line 200 of a locked frame");
        expect_event(1, 0, 1, 526, 2);
        apply_stimulus(200, 2, 8, -1, 8, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_all_zero("midframe_reset");
        RESET = 1'b0;

        apply_stimulus(525, 2, 8, -1, 8, 1'b0);
        expect_event(1, 0, 0, 525, 2);
        apply_stimulus(525, 2, 8, -1, 8, 1'b0);
        expect_event(1, 0, 1, 525, 2);
        apply_stimulus(525, 2, 8, -1, 8, 1'b0);
`ifdef VSYNC_LINE_PERIOD_MEASURE_EN
        check_output("line_period", 32'(bus.line_period), 8);
`else
        check_output("line_period", 32'(bus.line_period), 0);
`endif

        $display("[TB] one 10-CLK line while locked");
        expect_event(1, 0, 1, 525, 2);
        apply_stimulus(525, 2, 8, 100, 10, 1'b0);
`ifdef VSYNC_LINE_PERIOD_MEASURE_EN
        expect_event(1, 1, 0, 525, 2);
`else
        expect_event(1, 0, 1, 525, 2);
`endif
        apply_stimulus(525, 2, 8, -1, 8, 1'b0);

        $display("[TB] vsync held high for 1100 lines");
        expect_event(0, 1, 0, 525, 2);
        apply_stimulus(1100, 0, 8, -1, 8, 1'b0);
        check_output("timeout_yposition", 32'(bus.yposition), 1023);
        check_output("timeout_locked", 32'(bus.locked), 0);

        apply_stimulus(3, 2, 8, -1, 8, 1'b0);
        repeat (10) @(negedge CLK);
        check_output("after_timeout_locked", 32'(bus.locked), 0);
        check_output("pending_events", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
